// File: rtl/alu_share_ctrl_pkg.sv
// Shared ALU op codes, sequencer states and flag layout for the two-client ALU share.
package alu_share_ctrl_pkg;

   localparam int unsigned ALU_W    = 32;
   localparam int unsigned ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;
   localparam logic [ALU_OP_W-1:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic err;
      logic overflow;
      logic carry_out;
      logic zero;
   } alu_flags_t;

endpackage

// File: rtl/alu_32.sv
// Combinational 32-bit ALU; illegal op codes give zero result, zero flags and legal_c low.
module alu_32
   import alu_share_ctrl_pkg::*;
(
   input  logic [ALU_W-1:0]    a,
   input  logic [ALU_W-1:0]    b,
   input  logic [ALU_OP_W-1:0] op,
   output logic [ALU_W-1:0]    res_c,
   output logic                overflow_c,
   output logic                carry_c,
   output logic                zero_c,
   output logic                legal_c
);

   logic [ALU_W:0] sum;
   logic [ALU_W:0] diff;

   always_comb begin
      sum        = {1'b0, a} + {1'b0, b};
      // subtract as a + ~b + 1 so carry_out is the "no borrow" bit
      diff       = {1'b0, a} + {1'b0, ~b} + (ALU_W + 1)'(1);
      res_c      = '0;
      overflow_c = 1'b0;
      carry_c    = 1'b0;
      legal_c    = 1'b1;
      case (op)
         ALU_AND: res_c = a & b;
         ALU_OR:  res_c = a | b;
         ALU_ADD: begin
            res_c      = sum[ALU_W-1:0];
            carry_c    = sum[ALU_W];
            overflow_c = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
         end
         ALU_SUB: begin
            res_c      = diff[ALU_W-1:0];
            carry_c    = diff[ALU_W];
            overflow_c = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
         end
         ALU_SLT: res_c = ALU_W'($signed(a) < $signed(b));
         ALU_NOR: res_c = ~(a | b);
         default: legal_c = 1'b0;
      endcase
      zero_c = legal_c && (res_c == '0);
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin share of one alu_32 between two valid/ready clients: IDLE grant, EXEC compute,
// RESP hold result on the owner's response channel until consumed.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_W,
   parameter int unsigned OP_W   = ALU_OP_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_res,
   output logic [3:0]        rsp0_flags,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_res,
   output logic [3:0]        rsp1_flags,
   output logic              busy,
   output logic [CNT_W-1:0]  op_count
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              owner_q, owner_d;
   logic              prio_q, prio_d;
   logic              grant0, grant1;
   logic              rsp0_valid_d, rsp1_valid_d, busy_d;
   logic [DATA_W-1:0] rsp0_res_d, rsp1_res_d;
   logic [3:0]        rsp0_flags_d, rsp1_flags_d;
   logic [CNT_W-1:0]  op_count_d;

   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf, alu_carry, alu_zero, alu_legal;
   alu_flags_t        alu_flags;

   alu_32 u_alu (
      .a          (a_q),
      .b          (b_q),
      .op         (op_q),
      .res_c      (alu_res),
      .overflow_c (alu_ovf),
      .carry_c    (alu_carry),
      .zero_c     (alu_zero),
      .legal_c    (alu_legal)
   );

   always_comb begin
      alu_flags.err       = ~alu_legal;
      alu_flags.overflow  = alu_ovf;
      alu_flags.carry_out = alu_carry;
      alu_flags.zero      = alu_zero;
   end

   // prio_q names the requester that wins a tie
   always_comb begin
      grant0     = req0_valid & (~req1_valid | ~prio_q);
      grant1     = req1_valid & (~req0_valid |  prio_q);
      req0_ready = (state_q == IDLE) & grant0 & ~rst;
      req1_ready = (state_q == IDLE) & grant1 & ~rst;
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      owner_d      = owner_q;
      prio_d       = prio_q;
      rsp0_valid_d = rsp0_valid;
      rsp1_valid_d = rsp1_valid;
      rsp0_res_d   = rsp0_res;
      rsp1_res_d   = rsp1_res;
      rsp0_flags_d = rsp0_flags;
      rsp1_flags_d = rsp1_flags;
      op_count_d   = op_count;
      case (state_q)
         IDLE: begin
            if (grant0 | grant1) begin
               state_d = EXEC;
               owner_d = grant1;
               prio_d  = ~grant1;
               a_d     = grant1 ? req1_a  : req0_a;
               b_d     = grant1 ? req1_b  : req0_b;
               op_d    = grant1 ? req1_op : req0_op;
            end
         end
         EXEC: begin
            state_d = RESP;
            if (owner_q) begin
               rsp1_valid_d = 1'b1;
               rsp1_res_d   = alu_res;
               rsp1_flags_d = alu_flags;
            end else begin
               rsp0_valid_d = 1'b1;
               rsp0_res_d   = alu_res;
               rsp0_flags_d = alu_flags;
            end
         end
         RESP: begin
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               state_d      = IDLE;
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               op_count_d   = op_count + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         owner_q    <= 1'b0;
         prio_q     <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_res   <= '0;
         rsp1_res   <= '0;
         rsp0_flags <= '0;
         rsp1_flags <= '0;
         busy       <= 1'b0;
         op_count   <= '0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         owner_q    <= owner_d;
         prio_q     <= prio_d;
         rsp0_valid <= rsp0_valid_d;
         rsp1_valid <= rsp1_valid_d;
         rsp0_res   <= rsp0_res_d;
         rsp1_res   <= rsp1_res_d;
         rsp0_flags <= rsp0_flags_d;
         rsp1_flags <= rsp1_flags_d;
         busy       <= busy_d;
         op_count   <= op_count_d;
      end
   end

endmodule
